flag_ctx_reg: RTL
=================

# flag_ctx_reg

Parametrised processor status-flag register with per-flag write enables, pipeline stall/flush qualification and a hardware LIFO of saved flag contexts for interrupt entry and return. It sits at the write-back boundary of the 16-bit 5-stage pipeline. It takes ALU flags from the execute/write-back stage and feeds committed flags to branch resolution. A combinational forward path lets branch logic see flags being written in the same cycle.

## Interface
- NFLAGS, 4: number of flag bits; bit order per shared package (C=0, Z=1, V=2, S=3).
- DEPTH, 4: number of saved contexts in the LIFO; must be ≥1.
- CLR_ON_PUSH, 0: 1 = flags clear to 0 on push when no write is accepted that cycle.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flag_i  in  NFLAGS  new flag values from the ALU.
- we  in  NFLAGS  per-flag write mask.
- stall  in  1  freeze all state except the error clear.
- flush  in  1  squash the current write; we is ignored.
- push  in  1  save current flags to the LIFO (interrupt entry).
- pop  in  1  restore flags from the LIFO (interrupt return).
- err_clr  in  1  clear the sticky error flags.
- flag_o  out  NFLAGS  committed flag register.
- flag_fwd  out  NFLAGS  combinational view: flag_o with the accepted write merged in.
- depth_o  out  $clog2(DEPTH+1)  number of saved contexts.
- full  out  1  depth_o == DEPTH.
- empty  out  1  depth_o == 0.
- ovf_err  out  1  sticky; set by push while full.
- unf_err  out  1  sticky; set by pop while empty.

## Operation
- Accepted write: wr_ok = we & {NFLAGS{~stall & ~flush}}.
- Merged value: merged = (flag_o & ~wr_ok) | (flag_i & wr_ok).
- flag_fwd = merged at all times, including during stall.
- Priority when ~stall, highest first:
  1. push & pop together: both ignored, the stack is unchanged, flag_o <= merged, no error.
  2. pop, stack not empty: flag_o <= top entry, depth decrements, the write is dropped.
  3. pop, stack empty: unf_err <= 1, flag_o <= merged.
  4. push, stack not full: the entry at index depth <= flag_o (the pre-write value), depth increments. flag_o <= merged if |wr_ok; else 0 if CLR_ON_PUSH, else unchanged.
  5. push, stack full: ovf_err <= 1, the stack is unchanged, flag_o <= merged.
  6. Otherwise: flag_o <= merged.
- stall=1: flag_o, the stack, depth and error flags all hold. err_clr still acts.
- err_clr clears ovf_err and unf_err. If a new error event occurs in the same cycle, the set wins.
- LIFO entries beyond depth are don't-care and are not reset.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the system):
  - flag_o = 0, depth_o = 0, empty = 1, full = 0, ovf_err = 0, unf_err = 0.
  - flag_fwd = 0 while we = 0.
- Write latency: flag_o reflects an accepted write 1 cycle after the edge; flag_fwd reflects it in the same cycle.
- Push/pop: depth_o, full and empty update 1 cycle after the edge. Restored flags appear on flag_o 1 cycle after pop.
- Back-to-back push then pop on consecutive cycles restores exactly the flags saved by the push.
- rst asserted mid-operation immediately empties the stack and clears all outputs. There is no partial state.

## Structure
- Shared package flag_pkg holds:
  - Flag index constants FLAG_C, FLAG_Z, FLAG_V, FLAG_S.
  - Default NFLAGS.
  - Flag vector typedef.
- Sub-module flag_lifo: DEPTH×NFLAGS storage with pointer, full/empty, push/pop and a top-entry read port. flag_ctx_reg owns the priority logic, the flag register and the error flags.

## Test plan
- Reset, then flag_i=4'b1011, we=4'b1111 → flag_fwd=1011 in the same cycle; flag_o=1011 the next cycle.
- flag_o=1011, flag_i=0000, we=0010; next cycle stall=1, flag_i=1111, we=1111 → flag_o=1001 and then holds 1001; flag_fwd=1001 during the stall.
- flush=1 with we=1111 → flag_o unchanged.
- flag_o=0101, push with we=1111, flag_i=1110 → stack top=0101, flag_o=1110, depth_o=1. Then pop → flag_o=0101, depth_o=0, empty=1.
- DEPTH=4: five pushes → depth_o=4, full=1, ovf_err=1, stack contents intact. Pop with empty stack → unf_err=1. err_clr → both errors 0.
- CLR_ON_PUSH=1: flag_o=1111, push with we=0 → flag_o=0000, top=1111. Simultaneous push & pop → depth_o unchanged, no error. rst during depth_o=3 → depth_o=0, flag_o=0 immediately.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared flag definitions: bit positions of the status flags and the default flag vector.
package flag_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 3;

  localparam int NFLAGS_DEFAULT = 4;

  typedef logic [NFLAGS_DEFAULT-1:0] flag_vec_t;

endpackage

// File: rtl/flag_lifo.sv
// LIFO of saved flag contexts. The owner guarantees push/pop are never asserted together
// and never push when full or pop when empty.
module flag_lifo
  import flag_pkg::*;
#(
  parameter int NFLAGS = NFLAGS_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int DW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [NFLAGS-1:0] din_i,
  output logic [NFLAGS-1:0] top_o,
  output logic [DW-1:0]     depth_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [NFLAGS-1:0] mem_q [DEPTH];
  logic [DW-1:0]     depth_q;
  logic [DW-1:0]     depth_d;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o) begin
      depth_d = depth_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Storage is deliberately left out of reset; entries above depth are don't-care.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && !full_o && (depth_q == DW'(i))) begin
        mem_q[i] <= din_i;
      end
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        top_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/flag_ctx_reg.sv
// Committed status-flag register with write forwarding, stall/flush qualification and
// a saved-context LIFO for interrupt entry/return, plus sticky overflow/underflow errors.
module flag_ctx_reg
  import flag_pkg::*;
#(
  parameter int NFLAGS      = NFLAGS_DEFAULT,
  parameter int DEPTH       = 4,
  parameter bit CLR_ON_PUSH = 1'b0,
  parameter int DW          = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NFLAGS-1:0] flag_i,
  input  logic [NFLAGS-1:0] we,
  input  logic              stall,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [NFLAGS-1:0] flag_o,
  output logic [NFLAGS-1:0] flag_fwd,
  output logic [DW-1:0]     depth_o,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err
);

  logic [NFLAGS-1:0] flag_q, flag_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [NFLAGS-1:0] wr_ok;
  logic [NFLAGS-1:0] merged;
  logic [NFLAGS-1:0] lifo_top;
  logic              lifo_push, lifo_pop;
  logic              ovf_set, unf_set;
  logic              lifo_full, lifo_empty;

  assign wr_ok    = we & {NFLAGS{~stall & ~flush}};
  assign merged   = (flag_q & ~wr_ok) | (flag_i & wr_ok);
  assign flag_fwd = merged;

  flag_lifo #(
    .NFLAGS (NFLAGS),
    .DEPTH  (DEPTH),
    .DW     (DW)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lifo_push),
    .pop_i   (lifo_pop),
    .din_i   (flag_q),
    .top_o   (lifo_top),
    .depth_o (depth_o),
    .full_o  (lifo_full),
    .empty_o (lifo_empty)
  );

  // Push/pop priority; a stalled cycle leaves flags, stack and error sets untouched.
  always_comb begin
    flag_d    = flag_q;
    lifo_push = 1'b0;
    lifo_pop  = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (!stall) begin
      if (push && pop) begin
        flag_d = merged;
      end else if (pop && !lifo_empty) begin
        lifo_pop = 1'b1;
        flag_d   = lifo_top;
      end else if (pop) begin
        unf_set = 1'b1;
        flag_d  = merged;
      end else if (push && !lifo_full) begin
        lifo_push = 1'b1;
        if (|wr_ok) begin
          flag_d = merged;
        end else if (CLR_ON_PUSH) begin
          flag_d = '0;
        end else begin
          flag_d = flag_q;
        end
      end else if (push) begin
        ovf_set = 1'b1;
        flag_d  = merged;
      end else begin
        flag_d = merged;
      end
    end
  end

  assign ovf_d = ovf_set | (ovf_q & ~err_clr);
  assign unf_d = unf_set | (unf_q & ~err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign flag_o  = flag_q;
  assign full    = lifo_full;
  assign empty   = lifo_empty;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule
